// File: rtl/alu_half_sequencer.sv
// ---------------------------------------------------------------------------
// alu_half_sequencer
//
// Purpose:
//   Sits between the 32-bit execute stage and a 16-bit two-pass ALU. It takes
//   one 32-bit operation per in_valid_i/in_ready_o handshake. It feeds the ALU
//   two 16-bit halves in the order the op needs, and strobes first_cycle on
//   the first pass. It then reassembles the half results, or an early compare
//   verdict, into one 32-bit result. That result is offered on an
//   out_valid_o/out_ready_i handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid_i/in_ready_o request handshake
//   op_i, cmp_flip_i      requested ALU op and compare inversion
//   a_i, b_i              32-bit operands
//   alu_op_o              op presented to the ALU
//   alu_cmp_flip_o        compare inversion presented to the ALU
//   alu_first_cycle_o     high on the ALU's first pass
//   alu_a_o, alu_b_o      16-bit half operands to the ALU
//   alu_result_i          16-bit half result from the ALU
//   alu_cmp_result_i      compare result from the ALU
//   alu_cmp_valid_i       ALU could decide the compare on the first pass
//   alu_shift_ge16_i      ALU reports a shift amount >= 16
//   out_valid_o           result handshake valid
//   out_ready_i           result handshake ready
//   result_o              assembled 32-bit result
//
// Only XLEN = 32 is supported, which makes HALF = 16.
// ---------------------------------------------------------------------------
package alu_half_sequencer_pkg;
  typedef enum logic [3:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_AND,
    ALU_OP_OR,
    ALU_OP_XOR,
    ALU_OP_PLUS_4,
    ALU_OP_EQ,
    ALU_OP_LT,
    ALU_OP_LTU,
    ALU_OP_SRL,
    ALU_OP_SRA,
    ALU_OP_SLL
  } cs_alu_op;
endpackage

module alu_half_sequencer
  import alu_half_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  cs_alu_op            op_i,
  input  logic                cmp_flip_i,
  input  logic [XLEN-1:0]     a_i,
  input  logic [XLEN-1:0]     b_i,
  output cs_alu_op            alu_op_o,
  output logic                alu_cmp_flip_o,
  output logic                alu_first_cycle_o,
  output logic [XLEN/2-1:0]   alu_a_o,
  output logic [XLEN/2-1:0]   alu_b_o,
  input  logic [XLEN/2-1:0]   alu_result_i,
  input  logic                alu_cmp_result_i,
  input  logic                alu_cmp_valid_i,
  input  logic                alu_shift_ge16_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     result_o
);

  localparam int HALF = XLEN / 2;

  // The ALU adds 4 only to the low half. If the low half is at or above this
  // value, the +4 wraps, and the sequencer must carry 1 into the high half.
  localparam logic [HALF-1:0] PLUS4_WRAP = HALF'(16'hFFFC);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_SECOND,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  cs_alu_op        op_q, op_d;
  logic            flip_q, flip_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            ge16_q, ge16_d;

  logic            is_cmp;
  logic            is_shr;
  logic            is_sll;
  logic            plus4_carry;
  logic [HALF-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = a_q[HALF-1:0];
  assign a_hi = a_q[XLEN-1:HALF];
  assign b_lo = b_q[HALF-1:0];
  assign b_hi = b_q[XLEN-1:HALF];

  assign is_cmp      = op_q inside {ALU_OP_EQ, ALU_OP_LT, ALU_OP_LTU};
  assign is_shr      = op_q inside {ALU_OP_SRL, ALU_OP_SRA};
  assign is_sll      = (op_q == ALU_OP_SLL);
  assign plus4_carry = (a_lo >= PLUS4_WRAP);

  assign in_ready_o        = (state_q == ST_IDLE);
  assign out_valid_o       = (state_q == ST_DONE);
  assign alu_first_cycle_o = (state_q == ST_FIRST);
  assign alu_op_o          = op_q;
  assign alu_cmp_flip_o    = flip_q;
  assign result_o          = result_q;

  // Next-state and result assembly.
  // Each pass writes its half of the result as soon as the half arrives.
  // Right shifts produce the high half first. Everything else, including SLL,
  // produces the low half first. A compare writes the whole result from
  // whichever pass decides it.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    flip_d   = flip_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ge16_d   = ge16_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          op_d    = op_i;
          flip_d  = cmp_flip_i;
          a_d     = a_i;
          b_d     = b_i;
          state_d = ST_FIRST;
        end
      end

      ST_FIRST: begin
        ge16_d = alu_shift_ge16_i;
        if (is_cmp) begin
          result_d = {{(XLEN-1){1'b0}}, alu_cmp_result_i};
          state_d  = alu_cmp_valid_i ? ST_DONE : ST_SECOND;
        end else if (is_shr) begin
          result_d[XLEN-1:HALF] = alu_result_i;
          state_d               = ST_SECOND;
        end else begin
          result_d[HALF-1:0] = alu_result_i;
          state_d            = ST_SECOND;
        end
      end

      ST_SECOND: begin
        if (is_cmp) begin
          result_d = {{(XLEN-1){1'b0}}, alu_cmp_result_i};
        end else if (is_shr) begin
          result_d[HALF-1:0] = alu_result_i;
        end else if (op_q == ALU_OP_PLUS_4) begin
          result_d[XLEN-1:HALF] = alu_result_i + HALF'(plus4_carry);
        end else begin
          result_d[XLEN-1:HALF] = alu_result_i;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Half-operand steering.
  // Compares start with the high halves, because those can settle the compare
  // early. A shift of 16 or more reuses the same source half on the second
  // pass. Otherwise the second pass takes the other half.
  always_comb begin
    alu_a_o = '0;
    alu_b_o = '0;

    case (state_q)
      ST_FIRST: begin
        if (is_cmp) begin
          alu_a_o = a_hi;
          alu_b_o = b_hi;
        end else if (is_shr) begin
          alu_a_o = a_hi;
          alu_b_o = b_lo;
        end else begin
          alu_a_o = a_lo;
          alu_b_o = b_lo;
        end
      end

      ST_SECOND: begin
        if (is_cmp) begin
          alu_a_o = a_lo;
          alu_b_o = b_lo;
        end else if (is_shr) begin
          alu_a_o = ge16_q ? a_hi : a_lo;
          alu_b_o = b_lo;
        end else if (is_sll) begin
          alu_a_o = ge16_q ? a_lo : a_hi;
          alu_b_o = b_lo;
        end else begin
          alu_a_o = a_hi;
          alu_b_o = b_hi;
        end
      end

      default: begin
        alu_a_o = '0;
        alu_b_o = '0;
      end
    endcase
  end

  // State and operand registers.
  // Reset also clears the latched op to ADD, so the ALU sees a benign op
  // while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= ALU_OP_ADD;
      flip_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ge16_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      flip_q   <= flip_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ge16_q   <= ge16_d;
    end
  end

endmodule
